// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin arbiter sharing one BRAM port among requesters
//
// Purpose: grants one single-beat transaction per cycle to one of NUM_REQ
// requesters (round-robin from a registered pointer), drives the BRAM port
// from the granted requester in the same cycle, and routes read data back
// READ_LATENCY cycles after the grant to the requester that issued the read.
//
// Optional feature macro: BRAM_ARB_LOCK_EN (burst lock, capped at MAX_BURST).
//
// Ports:
//   aclk, aresetn       clock and synchronous active-low reset
//   req, lock           per-requester request and burst-lock hint
//   req_addr/wrdata/we  flattened per-requester transaction fields
//   gnt                 one-hot grant (transaction accepted this cycle)
//   rd_valid, rd_data   one-hot read-return strobe and broadcast read data
//   BRAM_*              block-memory port (BRAM_CLK mirrors aclk)

module bram_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      lock,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wrdata,
    input  logic [NUM_REQ*4-1:0]    req_we,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rd_valid,
    output logic [31:0]             rd_data,
    output logic [31:0]             BRAM_ADDR,
    output logic [31:0]             BRAM_WRDATA,
    output logic [3:0]              BRAM_WE,
    output logic                    BRAM_CLK,
    input  logic [31:0]             BRAM_RDDATA
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_ptr_inc;
    logic               w_found;
    logic               w_gnt_valid;
    logic               w_is_read;
    int                 w_cand;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wrdata;
    logic [3:0]         w_sel_we;
    logic [31:0]        r_addr_hold;
    logic [31:0]        r_wrdata_hold;

    // Read-return tracking: stage READ_LATENCY-1 is the one presented now.
    logic [READ_LATENCY-1:0]            r_pipe_vld;
    logic [READ_LATENCY-1:0][IDX_W-1:0] r_pipe_idx;

`ifdef BRAM_ARB_LOCK_EN
    logic               r_lock_act;
    logic [IDX_W-1:0]   r_lock_idx;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [CNT_W-1:0]   w_cnt_base;
`else
    logic               w_unused;
    assign w_unused = ^{lock, CNT_W'(MAX_BURST)};
`endif

    assign BRAM_CLK = aclk;
    assign rd_data  = BRAM_RDDATA;

    // First requesting index at or above the pointer, with wrap-around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(w_cand);
            end
        end
`ifdef BRAM_ARB_LOCK_EN
        // A still-requesting locked owner overrides the rotation.
        if (r_lock_act && req[r_lock_idx]) begin
            w_found = 1'b1;
            w_sel   = r_lock_idx;
        end
`endif
    end

    assign w_gnt_valid  = w_found && aresetn;
    assign w_ptr_inc    = (w_sel == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
    assign w_sel_addr   = req_addr[32*int'(w_sel) +: 32];
    assign w_sel_wrdata = req_wrdata[32*int'(w_sel) +: 32];
    assign w_sel_we     = req_we[4*int'(w_sel) +: 4];
    assign w_is_read    = (w_sel_we == 4'h0);

`ifdef BRAM_ARB_LOCK_EN
    // Count continues only while the same owner keeps its lock.
    assign w_cnt_base = (r_lock_act && (w_sel == r_lock_idx)) ? r_burst_cnt : '0;
`endif

    always_comb begin
        gnt = '0;
        if (w_gnt_valid) begin
            gnt[w_sel] = 1'b1;
        end
    end

    // Address/data hold the last granted values while idle; forced to zero in reset.
    always_comb begin
        BRAM_ADDR   = '0;
        BRAM_WRDATA = '0;
        BRAM_WE     = 4'h0;
        if (aresetn) begin
            BRAM_ADDR   = w_gnt_valid ? w_sel_addr   : r_addr_hold;
            BRAM_WRDATA = w_gnt_valid ? w_sel_wrdata : r_wrdata_hold;
            BRAM_WE     = w_gnt_valid ? w_sel_we     : 4'h0;
        end
    end

    always_comb begin
        rd_valid = '0;
        if (aresetn && r_pipe_vld[READ_LATENCY-1]) begin
            rd_valid[r_pipe_idx[READ_LATENCY-1]] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_ptr         <= '0;
            r_addr_hold   <= '0;
            r_wrdata_hold <= '0;
            r_pipe_vld    <= '0;
            r_pipe_idx    <= '0;
`ifdef BRAM_ARB_LOCK_EN
            r_lock_act    <= 1'b0;
            r_lock_idx    <= '0;
            r_burst_cnt   <= '0;
`endif
        end else begin
            if (w_gnt_valid) begin
                r_addr_hold   <= w_sel_addr;
                r_wrdata_hold <= w_sel_wrdata;
            end

            for (int s = READ_LATENCY - 1; s > 0; s--) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_idx[s] <= r_pipe_idx[s-1];
            end
            r_pipe_vld[0] <= w_gnt_valid && w_is_read;
            r_pipe_idx[0] <= w_sel;

`ifdef BRAM_ARB_LOCK_EN
            if (w_gnt_valid && lock[w_sel]) begin
                if (w_cnt_base == CNT_W'(MAX_BURST - 1)) begin
                    // Burst cap reached: release the lock and rotate past the owner.
                    r_ptr       <= w_ptr_inc;
                    r_burst_cnt <= '0;
                    r_lock_act  <= 1'b0;
                end else begin
                    r_burst_cnt <= w_cnt_base + 1'b1;
                    r_lock_act  <= 1'b1;
                    r_lock_idx  <= w_sel;
                end
            end else begin
                if (w_gnt_valid) begin
                    r_ptr <= w_ptr_inc;
                end
                r_burst_cnt <= '0;
                r_lock_act  <= 1'b0;
            end
`else
            if (w_gnt_valid) begin
                r_ptr <= w_ptr_inc;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard bench for bram_port_arbiter
module tb_bram_port_arbiter;

    typedef struct {
        int         due;
        logic [3:0] oh;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A: READ_LATENCY=1
    logic         a_resetn;
    logic [3:0]   a_req, a_lock, a_gnt, a_rdv, a_bwe;
    logic [127:0] a_addr, a_wd;
    logic [15:0]  a_we;
    logic [31:0]  a_rdd, a_baddr, a_bwd, a_brd;
    logic         a_bclk;

    // Instance B: READ_LATENCY=2
    logic         b_resetn;
    logic [3:0]   b_req, b_lock, b_gnt, b_rdv, b_bwe;
    logic [127:0] b_addr, b_wd;
    logic [15:0]  b_we;
    logic [31:0]  b_rdd, b_baddr, b_bwd, b_brd;
    logic         b_bclk;

    bram_port_arbiter #(.NUM_REQ(4), .READ_LATENCY(1), .MAX_BURST(4)) u_dut (
        .aclk(clk), .aresetn(a_resetn), .req(a_req), .lock(a_lock),
        .req_addr(a_addr), .req_wrdata(a_wd), .req_we(a_we),
        .gnt(a_gnt), .rd_valid(a_rdv), .rd_data(a_rdd),
        .BRAM_ADDR(a_baddr), .BRAM_WRDATA(a_bwd), .BRAM_WE(a_bwe),
        .BRAM_CLK(a_bclk), .BRAM_RDDATA(a_brd)
    );

    bram_port_arbiter #(.NUM_REQ(4), .READ_LATENCY(2), .MAX_BURST(16)) u_dut2 (
        .aclk(clk), .aresetn(b_resetn), .req(b_req), .lock(b_lock),
        .req_addr(b_addr), .req_wrdata(b_wd), .req_we(b_we),
        .gnt(b_gnt), .rd_valid(b_rdv), .rd_data(b_rdd),
        .BRAM_ADDR(b_baddr), .BRAM_WRDATA(b_bwd), .BRAM_WE(b_bwe),
        .BRAM_CLK(b_bclk), .BRAM_RDDATA(b_brd)
    );

    // Read-first BRAM models; word i preloads to 0xA0000000 | (i*4) during reset.
    logic [31:0] mem_a [0:255];
    logic [31:0] rd_a;
    always @(posedge clk) begin
        if (!a_resetn) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'hA000_0000 | (i << 2);
        end else begin
            for (int b = 0; b < 4; b++)
                if (a_bwe[b]) mem_a[a_baddr[9:2]][8*b +: 8] <= a_bwd[8*b +: 8];
        end
        rd_a <= mem_a[a_baddr[9:2]];
    end
    assign a_brd = rd_a;

    logic [31:0] mem_b [0:255];
    logic [31:0] rd_b1, rd_b2;
    always @(posedge clk) begin
        if (!b_resetn) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 32'hA000_0000 | (i << 2);
        end else begin
            for (int b = 0; b < 4; b++)
                if (b_bwe[b]) mem_b[b_baddr[9:2]][8*b +: 8] <= b_bwd[8*b +: 8];
        end
        rd_b1 <= mem_b[b_baddr[9:2]];
        rd_b2 <= rd_b1;
    end
    assign b_brd = rd_b2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req_v, cyc);
        end
    endtask

    // Monitors: pop an expectation whenever a read return is presented.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_rdv != 4'h0) begin
            if (qa.size() == 0) begin
                chk("a_rd_unexpected", {28'h0, a_rdv}, 32'h0);
            end else begin
                e = qa.pop_front();
                chk("a_rd_valid", {28'h0, a_rdv}, {28'h0, e.oh});
                chk("a_rd_data", a_rdd, e.data);
                chk("a_rd_cycle", cyc, e.due);
            end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            chk("a_rd_missing", 32'h0, {28'h0, e.oh});
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_rdv != 4'h0) begin
            if (qb.size() == 0) begin
                chk("b_rd_unexpected", {28'h0, b_rdv}, 32'h0);
            end else begin
                e = qb.pop_front();
                chk("b_rd_valid", {28'h0, b_rdv}, {28'h0, e.oh});
                chk("b_rd_data", b_rdd, e.data);
                chk("b_rd_cycle", cyc, e.due);
            end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
            e = qb.pop_front();
            chk("b_rd_missing", 32'h0, {28'h0, e.oh});
        end
    end

    task automatic set_a(input int i, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] we);
        a_addr[32*i +: 32] = addr;
        a_wd[32*i +: 32]   = wd;
        a_we[4*i +: 4]     = we;
        a_req[i]           = 1'b1;
    endtask

    // One cycle on A: check grant and port mux, push expected read return.
    task automatic step_a(input logic [3:0] eg, input logic [31:0] ea, input logic [31:0] ewd,
                          input logic [3:0] ewe, input int ri, input logic [31:0] rdat);
        @(negedge clk);
        chk("a_gnt", {28'h0, a_gnt}, {28'h0, eg});
        chk("a_bram_addr", a_baddr, ea);
        chk("a_bram_wrdata", a_bwd, ewd);
        chk("a_bram_we", {28'h0, a_bwe}, {28'h0, ewe});
        if (ri >= 0) qa.push_back('{due: cyc + 1, oh: 4'(1 << ri), data: rdat});
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [3:0] eg, input int ri, input logic [31:0] rdat);
        @(negedge clk);
        chk("b_gnt", {28'h0, b_gnt}, {28'h0, eg});
        if (ri >= 0) qb.push_back('{due: cyc + 2, oh: 4'(1 << ri), data: rdat});
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        logic [9:0] lock_seq;
        a_resetn = 1'b0; b_resetn = 1'b0;
        a_req = 4'hF; a_lock = 4'h0; a_wd = '0; a_we = '0;
        a_addr = {32'h40, 32'h30, 32'h20, 32'h10};
        b_req = 4'h0; b_lock = 4'h0; b_addr = '0; b_wd = '0; b_we = '0;

        // Reset held with requests present: outputs forced quiet.
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", {28'h0, a_gnt}, 32'h0);
            chk("rst_addr", a_baddr, 32'h0);
            chk("rst_we", {28'h0, a_bwe}, 32'h0);
            chk("rst_rdv", {28'h0, a_rdv}, 32'h0);
        end
        @(posedge clk); #1;
        a_resetn = 1'b1; b_resetn = 1'b1; a_req = 4'h0;
        repeat (10) step_a(4'h0, 32'h0, 32'h0, 4'h0, -1, 32'h0);

        // All four read; round-robin from pointer 0.
        set_a(0, 32'h10, 32'h0, 4'h0); set_a(1, 32'h20, 32'h0, 4'h0);
        set_a(2, 32'h30, 32'h0, 4'h0); set_a(3, 32'h40, 32'h0, 4'h0);
        step_a(4'b0001, 32'h10, 32'h0, 4'h0, 0, 32'hA000_0010); a_req[0] = 1'b0;
        step_a(4'b0010, 32'h20, 32'h0, 4'h0, 1, 32'hA000_0020); a_req[1] = 1'b0;
        step_a(4'b0100, 32'h30, 32'h0, 4'h0, 2, 32'hA000_0030); a_req[2] = 1'b0;
        step_a(4'b1000, 32'h40, 32'h0, 4'h0, 3, 32'hA000_0040); a_req[3] = 1'b0;

        // Write by requester 2, then read-back by requester 0, then idle hold.
        set_a(2, 32'h8, 32'hDEAD_BEEF, 4'hF);
        step_a(4'b0100, 32'h8, 32'hDEAD_BEEF, 4'hF, -1, 32'h0); a_req[2] = 1'b0;
        set_a(0, 32'h8, 32'h0, 4'h0);
        step_a(4'b0001, 32'h8, 32'h0, 4'h0, 0, 32'hDEAD_BEEF); a_req[0] = 1'b0;
        step_a(4'b0000, 32'h8, 32'h0, 4'h0, -1, 32'h0);

        // Requester 1 alone for 5 cycles, then requester 3 joins.
        set_a(1, 32'h4, 32'h0, 4'h0);
        repeat (5) step_a(4'b0010, 32'h4, 32'h0, 4'h0, 1, 32'hA000_0004);
        set_a(3, 32'hC, 32'h0, 4'h0);
        step_a(4'b1000, 32'hC, 32'h0, 4'h0, 3, 32'hA000_000C);
        step_a(4'b0010, 32'h4, 32'h0, 4'h0, 1, 32'hA000_0004);
        step_a(4'b1000, 32'hC, 32'h0, 4'h0, 3, 32'hA000_000C);
        a_req = 4'h0;
        step_a(4'b0000, 32'hC, 32'h0, 4'h0, -1, 32'h0);

`ifdef BRAM_ARB_LOCK_EN
        // Locked requester 0 against requester 1 with MAX_BURST=4.
        lock_seq = 10'b10_0001_0000;
        set_a(0, 32'h10, 32'h0, 4'h0); set_a(1, 32'h20, 32'h0, 4'h0);
        a_lock[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (lock_seq[k]) step_a(4'b0010, 32'h20, 32'h0, 4'h0, 1, 32'hA000_0020);
            else             step_a(4'b0001, 32'h10, 32'h0, 4'h0, 0, 32'hA000_0010);
        end
        a_req = 4'h0; a_lock = 4'h0;
`else
        lock_seq = 10'h0;
`endif

        // Instance B (latency 2): normal read, then reset right after a read grant.
        b_addr[31:0] = 32'h14; b_req[0] = 1'b1;
        step_b(4'b0001, 0, 32'hA000_0014); b_req = 4'h0;
        step_b(4'b0000, -1, 32'h0);
        step_b(4'b0000, -1, 32'h0);
        b_addr[63:32] = 32'h18; b_req[1] = 1'b1;
        step_b(4'b0010, -1, 32'h0);
        b_resetn = 1'b0; b_req = 4'b0011;
        @(negedge clk);
        chk("b_rst_gnt", {28'h0, b_gnt}, 32'h0);
        chk("b_rst_rdv", {28'h0, b_rdv}, 32'h0);
        @(posedge clk); #1;
        b_resetn = 1'b1;
        step_b(4'b0001, 0, 32'hA000_0014); b_req = 4'h0;
        repeat (5) step_b(4'b0000, -1, 32'h0);

        repeat (4) @(posedge clk);
        #1;
        chk("a_sb_empty", 32'(qa.size()), 32'h0);
        chk("b_sb_empty", 32'(qb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one BRAM port (32-bit address/data, 4-bit byte write enable) between NUM_REQ requesters, such as several pe_con instances or a host-side loader.
- Uses round-robin arbitration with single-beat transactions.
- Returns read data at a fixed READ_LATENCY to the requester that issued the read.
- Sits between the PE controllers and the my_bram / block-memory port.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- READ_LATENCY, 1: cycles from the grant cycle to valid BRAM_RDDATA (1..4).
- MAX_BURST, 16: maximum consecutive grants to one locked requester (used only with the optional feature).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester transaction request.
- lock  in  NUM_REQ  per-requester burst-lock hint; ignored unless the optional feature is compiled in.
- req_addr  in  NUM_REQ*32  flattened addresses; requester i uses bits [32i+31:32i].
- req_wrdata  in  NUM_REQ*32  flattened write data.
- req_we  in  NUM_REQ*4  flattened byte enables; all zero means a read.
- gnt  out  NUM_REQ  one-hot grant; the transaction is accepted in the same cycle.
- rd_valid  out  NUM_REQ  one-hot read-return strobe.
- rd_data  out  32  read data, broadcast to all requesters; valid where rd_valid is set.
- BRAM_ADDR  out  32  BRAM address.
- BRAM_WRDATA  out  32  BRAM write data.
- BRAM_WE  out  4  BRAM byte write enable.
- BRAM_CLK  out  1  equals aclk.
- BRAM_RDDATA  in  32  BRAM read data.

Behaviour:
- Reset (aresetn=0 sampled at the edge, and combinationally while held low):
  - gnt=0, rd_valid=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_WRDATA=0.
  - Round-robin pointer = 0; burst counter = 0; read-tracking pipeline cleared.
- Arbitration is combinational from req and the registered pointer.
  - Grant goes to the first requester with req=1, searching from the pointer upward with wrap-around.
  - At most one gnt bit is set per cycle; gnt=0 when req=0.
- BRAM_ADDR, BRAM_WRDATA and BRAM_WE are muxed from the granted requester in the same cycle.
  - With no grant: BRAM_WE=0, and BRAM_ADDR/BRAM_WRDATA hold their last granted values (registered copy).
- Handshake:
  - A requester holds req, addr, wrdata and we stable until it sees gnt=1.
  - The transaction completes at that edge.
  - The requester may keep req=1 for a back-to-back transaction; it must then be re-arbitrated.
- Pointer update on any grant: pointer <= granted index + 1 (mod NUM_REQ). No grant leaves the pointer unchanged.
- Read tracking:
  - A shift register READ_LATENCY deep carries {valid, index}.
  - A granted read (we==0) enters with valid=1; a granted write enters with valid=0.
  - rd_valid[index] asserts exactly READ_LATENCY cycles after the grant cycle, for one cycle.
  - rd_data = BRAM_RDDATA, passed through combinationally.
- Back-to-back reads from different requesters return in grant order, one per cycle, with no bubbles.
- Reset mid-operation discards all in-flight reads; no rd_valid is produced after the reset releases for those reads.
- A read and a write to the same address in consecutive cycles follow BRAM read-first semantics; the arbiter adds no hazard logic.

Optional Feature:
- Macro: BRAM_ARB_LOCK_EN.
- With the macro defined:
  - If the granted requester had lock=1 and still has req=1 next cycle, it keeps the grant regardless of the pointer.
  - The pointer is not advanced while locked.
  - A burst counter counts consecutive locked grants. At MAX_BURST the lock is broken: the pointer advances past the requester and the counter clears.
  - The counter also clears on any non-locked grant or an idle cycle.
- Without the macro: the lock input is unused and pure round-robin applies.

Test Plan:
- Reset hold, then release with all req=0 -> gnt=0, BRAM_WE=0, rd_valid=0 for 10 cycles.
- req=4'b1111 with reads to addresses 0x10, 0x20, 0x30, 0x40 (requesters 0..3), READ_LATENCY=1, BRAM preloaded -> grants in order 0,1,2,3 on consecutive cycles; rd_valid one-hot 0,1,2,3 one cycle later, each with matching data.
- Requester 2 writes 0xDEADBEEF to 0x8 with we=4'hF, then requester 0 reads 0x8 -> rd_valid[0]=1 with rd_data=0xDEADBEEF; no rd_valid produced for the write.
- Requester 1 alone holds req=1 for 5 cycles -> gnt[1]=1 on every cycle; the pointer wraps correctly when requester 3 then joins.
- Reset asserted one cycle after a read grant with READ_LATENCY=2 -> no rd_valid after reset.
- With BRAM_ARB_LOCK_EN, MAX_BURST=4: requester 0 has lock=1 and req=1 continuously, requester 1 has req=1 -> gnt sequence 0,0,0,0,1,0,0,0,0,1.
